decode_stage: RTL and testbench

- Registered, parametrised RV32I/RV64I decode stage sitting between the IF/ID boundary and the register-file read / ID-EX boundary.
- Splits the instruction into fields, classifies its format, generates the sign-extended immediate and flags illegal opcodes.
- Has a valid/ready handshake on both sides. A 2-entry skid buffer keeps in_ready a registered signal.
- Supports synchronous flush for branch mispredict and trap.

---
 rtl/decode_pkg.sv | 57 +++++
 rtl/decode_stage_if.sv | 35 +++
 rtl/decode_stage_imm_gen.sv | 36 +++
 rtl/decode_stage.sv | 108 ++++++++++
 tb/tb_decode_stage.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared types, opcode constants and the opcode-to-format lookup for the
// RV32I/RV64I decode stage and anything else that needs to classify instructions.
package decode_pkg;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   localparam logic [6:0] OP        = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] LOAD      = 7'h03;
   localparam logic [6:0] STORE     = 7'h23;
   localparam logic [6:0] BRANCH    = 7'h63;
   localparam logic [6:0] JAL       = 7'h6F;
   localparam logic [6:0] JALR      = 7'h67;
   localparam logic [6:0] LUI       = 7'h37;
   localparam logic [6:0] AUIPC     = 7'h17;
   localparam logic [6:0] SYSTEM    = 7'h73;
   localparam logic [6:0] MISC_MEM  = 7'h0F;
   localparam logic [6:0] OP_IMM_32 = 7'h1B;
   localparam logic [6:0] OP_32     = 7'h3B;

   // XLEN-independent part of a decoded bundle; pc and imm are added per instance.
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [2:0] func3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [6:0] func7;
      fmt_e       fmt;
      logic       illegal;
   } fields_t;

   function automatic fmt_e opcode_fmt(input logic [6:0] op, input logic allow_w);
      fmt_e f;
      case (op)
         OP:                                   f = FMT_R;
         OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: f = FMT_I;
         STORE:                                f = FMT_S;
         BRANCH:                               f = FMT_B;
         LUI, AUIPC:                           f = FMT_U;
         JAL:                                  f = FMT_J;
         OP_IMM_32:                            f = allow_w ? FMT_I : FMT_NONE;
         OP_32:                                f = allow_w ? FMT_R : FMT_NONE;
         default:                              f = FMT_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// The pipeline around the stage is the master; the stage itself is the slave.
interface decode_stage_if #(
   parameter int XLEN = 32
) ();

   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         in_instr;
   logic [XLEN-1:0]     in_pc;
   logic                out_valid;
   logic                out_ready;
   logic [XLEN-1:0]     out_pc;
   logic [6:0]          opcode;
   logic [4:0]          rd;
   logic [2:0]          func3;
   logic [4:0]          rs1;
   logic [4:0]          rs2;
   logic [6:0]          func7;
   decode_pkg::fmt_e    fmt;
   logic [XLEN-1:0]     imm;
   logic                illegal;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, opcode, rd, func3, rs1, rs2, func7, fmt, imm, illegal
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, opcode, rd, func3, rs1, rs2, func7, fmt, imm, illegal
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: instruction bits + format -> sign-extended immediate.
// Only instr[31:7] carries immediate bits, so the opcode is not part of the port.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     i_instr,
   input  fmt_e            i_fmt,
   output logic [XLEN-1:0] o_imm
);

   logic [31:0] w_imm32;

   always_comb begin
      w_imm32 = '0;
      case (i_fmt)
         FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                             i_instr[11:8], 1'b0};
         FMT_U:   w_imm32 = {i_instr[31:12], 12'b0};
         FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                             i_instr[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
   end

   // Every format's value is already correct as a signed 32-bit number, so RV64 only widens it.
   if (XLEN == 64) begin : g_xlen64
      assign o_imm = {{32{w_imm32[31]}}, w_imm32};
   end else begin : g_xlen32
      assign o_imm = w_imm32;
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with a two-entry (main + skid) buffer so that
// in_ready comes straight from a flop and never depends on out_ready.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit ALLOW_RV64W = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   decode_stage_if.slave bus
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("decode_stage: XLEN must be 32 or 64, got %0d", XLEN);
   end
   if (ALLOW_RV64W && XLEN == 32) begin : g_bad_rv64w
      $error("decode_stage: ALLOW_RV64W requires XLEN == 64");
   end

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      fields_t         f;
   } bundle_t;

   fields_t         w_fields;
   logic [XLEN-1:0] w_imm;
   bundle_t         w_bundle;
   logic            w_push;
   logic            w_pop;
   logic            w_main_free;

   bundle_t         r_main;
   bundle_t         r_skid;
   logic            r_main_valid;
   logic            r_skid_valid;
   logic            r_in_ready;

   always_comb begin
      w_fields.opcode  = bus.in_instr[6:0];
      w_fields.rd      = bus.in_instr[11:7];
      w_fields.func3   = bus.in_instr[14:12];
      w_fields.rs1     = bus.in_instr[19:15];
      w_fields.rs2     = bus.in_instr[24:20];
      w_fields.func7   = bus.in_instr[31:25];
      w_fields.fmt     = opcode_fmt(bus.in_instr[6:0], ALLOW_RV64W);
      w_fields.illegal = (w_fields.fmt == FMT_NONE) || (bus.in_instr[1:0] != 2'b11);
   end

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .i_instr (bus.in_instr[31:7]),
      .i_fmt   (w_fields.fmt),
      .o_imm   (w_imm)
   );

   assign w_bundle    = {bus.in_pc, w_imm, w_fields};
   assign w_push      = bus.in_valid && r_in_ready;
   assign w_pop       = r_main_valid && bus.out_ready;
   assign w_main_free = !r_main_valid || w_pop;

   // Skid can only hold data while main is full, so a draining main always refills from skid first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (bus.flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (w_main_free) begin
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
         end else if (w_push) begin
            r_main       <= w_bundle;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_push) begin
         r_skid       <= w_bundle;
         r_skid_valid <= 1'b1;
         r_in_ready   <= 1'b0;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_main_valid;
   assign bus.out_pc    = r_main.pc;
   assign bus.imm       = r_main.imm;
   assign bus.opcode    = r_main.f.opcode;
   assign bus.rd        = r_main.f.rd;
   assign bus.func3     = r_main.f.func3;
   assign bus.rs1       = r_main.f.rs1;
   assign bus.rs2       = r_main.f.rs2;
   assign bus.func7     = r_main.f.func7;
   assign bus.fmt       = r_main.f.fmt;
   assign bus.illegal   = r_main.f.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: an RV32 (no W ops) and an RV64 (W ops allowed) instance share
// one stimulus stream and are checked against a FIFO-of-instructions reference model.
module tb_decode_stage;
   import decode_pkg::*;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } entry_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  func3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  func7;
      logic [2:0]  fmt;
      logic        illegal;
      logic [63:0] imm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        inValid;
   logic        outReady;
   logic [31:0] instr;
   logic [63:0] pc;
   int          errors = 0;
   int          checks = 0;
   entry_t      modelQ[$];
   logic [6:0]  opList [13];

   decode_stage_if #(.XLEN(32)) bus32 ();
   decode_stage_if #(.XLEN(64)) bus64 ();

   assign bus32.flush     = flush;
   assign bus32.in_valid  = inValid;
   assign bus32.in_instr  = instr;
   assign bus32.in_pc     = pc[31:0];
   assign bus32.out_ready = outReady;
   assign bus64.flush     = flush;
   assign bus64.in_valid  = inValid;
   assign bus64.in_instr  = instr;
   assign bus64.in_pc     = pc;
   assign bus64.out_ready = outReady;

   decode_stage #(.XLEN(32), .ALLOW_RV64W(1'b0)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
   decode_stage #(.XLEN(64), .ALLOW_RV64W(1'b1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

   always #5 clk = ~clk;

   // Two's-complement sign extension of the low 'bits' bits of v, done arithmetically.
   function automatic logic [63:0] sext(logic [63:0] v, int bits);
      logic [63:0] m;
      logic [63:0] s;
      m = (64'd1 << bits) - 64'd1;
      s = 64'd1 << (bits - 1);
      return ((v & m) ^ s) - s;
   endfunction

   function automatic exp_t modelDecode(logic [31:0] ins, bit allowW);
      exp_t e;
      e.opcode = ins[6:0];
      e.rd     = ins[11:7];
      e.func3  = ins[14:12];
      e.rs1    = ins[19:15];
      e.rs2    = ins[24:20];
      e.func7  = ins[31:25];
      case (ins[6:0])
         7'h33:                             e.fmt = 3'd0;
         7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: e.fmt = 3'd1;
         7'h23:                             e.fmt = 3'd2;
         7'h63:                             e.fmt = 3'd3;
         7'h37, 7'h17:                      e.fmt = 3'd4;
         7'h6F:                             e.fmt = 3'd5;
         7'h1B:                             e.fmt = allowW ? 3'd1 : 3'd7;
         7'h3B:                             e.fmt = allowW ? 3'd0 : 3'd7;
         default:                           e.fmt = 3'd7;
      endcase
      e.illegal = (e.fmt == 3'd7) || (ins[1:0] != 2'b11);
      case (e.fmt)
         3'd1:    e.imm = sext(64'(ins[31:20]), 12);
         3'd2:    e.imm = sext(64'({ins[31:25], ins[11:7]}), 12);
         3'd3:    e.imm = sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
         3'd4:    e.imm = sext(64'({ins[31:12], 12'b0}), 32);
         3'd5:    e.imm = sext(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
         default: e.imm = 64'd0;
      endcase
      return e;
   endfunction

   function automatic logic [99:0] exp32(entry_t en);
      exp_t x;
      x = modelDecode(en.instr, 1'b0);
      return {x.opcode, x.rd, x.func3, x.rs1, x.rs2, x.func7, x.fmt, x.illegal, x.imm[31:0], en.pc[31:0]};
   endfunction

   function automatic logic [163:0] exp64(entry_t en);
      exp_t x;
      x = modelDecode(en.instr, 1'b1);
      return {x.opcode, x.rd, x.func3, x.rs1, x.rs2, x.func7, x.fmt, x.illegal, x.imm, en.pc};
   endfunction

   function automatic logic [99:0] got32();
      return {bus32.opcode, bus32.rd, bus32.func3, bus32.rs1, bus32.rs2, bus32.func7,
              bus32.fmt, bus32.illegal, bus32.imm, bus32.out_pc};
   endfunction

   function automatic logic [163:0] got64();
      return {bus64.opcode, bus64.rd, bus64.func3, bus64.rs1, bus64.rs2, bus64.func7,
              bus64.fmt, bus64.illegal, bus64.imm, bus64.out_pc};
   endfunction

   // Advance one clock and update the model: at most two instructions may be buffered.
   task automatic tick();
      bit     push;
      bit     pop;
      bit     fl;
      entry_t en;
      push = inValid && (modelQ.size() < 2);
      pop  = (modelQ.size() > 0) && outReady;
      fl   = flush;
      en   = '{instr: instr, pc: pc};
      @(posedge clk);
      #1;
      if (fl) begin
         modelQ.delete();
      end else begin
         if (pop) void'(modelQ.pop_front());
         if (push) modelQ.push_back(en);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0; instr = '0; pc = '0;
      #12;
      checks++;
      if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_out_valid got32=%b got64=%b exp=0", bus32.out_valid, bus64.out_valid);
      end
      checks++;
      if (bus32.in_ready !== 1'b1 || bus64.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_in_ready got32=%b got64=%b exp=1", bus32.in_ready, bus64.in_ready);
      end
      checks++;
      if (got32() !== 100'd0) begin
         errors++;
         $display("[TB] FAIL reset_regs32 got=%h exp=0", got32());
      end
      checks++;
      if (got64() !== 164'd0) begin
         errors++;
         $display("[TB] FAIL reset_regs64 got=%h exp=0", got64());
      end
      rst_n = 1'b1;
      modelQ.delete();
      tick();
   endtask

   task automatic test_decode();
      logic [31:0] tbl [9];
      entry_t      en;
      tbl = '{32'h00510093, 32'hFE512E23, 32'h123451B7, 32'hFFFFFFFF, 32'h0000007F,
              32'h0000001B, 32'h0000003B, 32'hFE000EE3, 32'h800000EF};
      outReady = 1'b1;
      for (int i = 0; i < 9; i++) begin
         inValid = 1'b1;
         instr   = tbl[i];
         pc      = 64'h100 + 64'(i * 4);
         en      = '{instr: instr, pc: pc};
         tick();
         checks++;
         if (bus32.out_valid !== 1'b1 || bus64.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL decode_valid[%0d] got32=%b got64=%b exp=1", i, bus32.out_valid, bus64.out_valid);
         end
         checks++;
         if (got32() !== exp32(en)) begin
            errors++;
            $display("[TB] FAIL decode32[%0d] got=%h exp=%h", i, got32(), exp32(en));
         end
         checks++;
         if (got64() !== exp64(en)) begin
            errors++;
            $display("[TB] FAIL decode64[%0d] got=%h exp=%h", i, got64(), exp64(en));
         end
         if (i == 0) begin
            checks++;
            if ({bus32.opcode, bus32.rd, bus32.rs1, bus32.func3, bus32.fmt, bus32.imm, bus32.out_pc, bus32.illegal}
                !== {7'h13, 5'd1, 5'd2, 3'd0, 3'd1, 32'd5, 32'h100, 1'b0}) begin
               errors++;
               $display("[TB] FAIL addi_fields got=%h", {bus32.opcode, bus32.rd, bus32.rs1, bus32.func3,
                        bus32.fmt, bus32.imm, bus32.out_pc, bus32.illegal});
            end
         end else if (i == 1) begin
            checks++;
            if ({bus32.fmt, bus32.rs1, bus32.rs2, bus32.func3, bus32.imm} !== {3'd2, 5'd2, 5'd5, 3'd2, 32'hFFFFFFFC}) begin
               errors++;
               $display("[TB] FAIL sw_fields got=%h", {bus32.fmt, bus32.rs1, bus32.rs2, bus32.func3, bus32.imm});
            end
         end else if (i == 2) begin
            checks++;
            if ({bus64.fmt, bus64.rd, bus64.imm, bus32.imm} !== {3'd4, 5'd3, 64'h0000000012345000, 32'h12345000}) begin
               errors++;
               $display("[TB] FAIL lui_fields got=%h", {bus64.fmt, bus64.rd, bus64.imm, bus32.imm});
            end
         end else if (i == 3 || i == 4) begin
            checks++;
            if ({bus32.illegal, bus32.fmt, bus32.imm, bus64.illegal, bus64.fmt, bus64.imm}
                !== {1'b1, 3'd7, 32'd0, 1'b1, 3'd7, 64'd0}) begin
               errors++;
               $display("[TB] FAIL illegal_fields[%0d] got=%h", i, {bus32.illegal, bus32.fmt, bus32.imm,
                        bus64.illegal, bus64.fmt, bus64.imm});
            end
         end else if (i == 5) begin
            checks++;
            if ({bus32.illegal, bus32.fmt, bus32.imm, bus64.illegal, bus64.fmt} !== {1'b1, 3'd7, 32'd0, 1'b0, 3'd1}) begin
               errors++;
               $display("[TB] FAIL rv64w_fields got=%h", {bus32.illegal, bus32.fmt, bus32.imm, bus64.illegal, bus64.fmt});
            end
         end
      end
      inValid = 1'b0;
      tick();
      checks++;
      if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL decode_idle got32=%b got64=%b exp=0", bus32.out_valid, bus64.out_valid);
      end
   endtask

   task automatic test_backpressure();
      entry_t a;
      entry_t b;
      a = '{instr: 32'h00510093, pc: 64'h200};
      b = '{instr: 32'hFE512E23, pc: 64'h204};
      outReady = 1'b0;
      inValid  = 1'b1; instr = a.instr; pc = a.pc;
      tick();
      checks++;
      if ({bus32.out_valid, bus32.in_ready, bus64.out_valid, bus64.in_ready} !== 4'b1111) begin
         errors++;
         $display("[TB] FAIL bp_after_a got=%b exp=1111", {bus32.out_valid, bus32.in_ready, bus64.out_valid, bus64.in_ready});
      end
      instr = b.instr; pc = b.pc;
      tick();
      inValid = 1'b0;
      checks++;
      if (bus32.in_ready !== 1'b0 || bus64.in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_full_in_ready got32=%b got64=%b exp=0", bus32.in_ready, bus64.in_ready);
      end
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (got32() !== exp32(a) || got64() !== exp64(a) || bus32.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_hold_a[%0d] got=%h exp=%h", s, got32(), exp32(a));
         end
         tick();
      end
      checks++;
      if (bus32.in_ready !== 1'b0 || bus64.in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_stall_in_ready got32=%b got64=%b exp=0", bus32.in_ready, bus64.in_ready);
      end
      outReady = 1'b1;
      tick();
      checks++;
      if (got32() !== exp32(b) || got64() !== exp64(b) || bus32.out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_then_b got=%h exp=%h", got32(), exp32(b));
      end
      checks++;
      if (bus32.in_ready !== 1'b1 || bus64.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_in_ready_rise got32=%b got64=%b exp=1", bus32.in_ready, bus64.in_ready);
      end
      tick();
      checks++;
      if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_drained got32=%b got64=%b exp=0", bus32.out_valid, bus64.out_valid);
      end
   endtask

   task automatic test_flush();
      entry_t d;
      outReady = 1'b0;
      inValid  = 1'b1;
      instr = 32'h00A00113; pc = 64'h300; tick();
      instr = 32'h00B00193; pc = 64'h304; tick();
      flush = 1'b1; instr = 32'h00C00213; pc = 64'h308;
      tick();
      flush = 1'b0; inValid = 1'b0;
      checks++;
      if ({bus32.out_valid, bus32.in_ready, bus64.out_valid, bus64.in_ready} !== 4'b0101) begin
         errors++;
         $display("[TB] FAIL flush_full got=%b exp=0101", {bus32.out_valid, bus32.in_ready, bus64.out_valid, bus64.in_ready});
      end
      outReady = 1'b1;
      for (int s = 0; s < 3; s++) begin
         tick();
         checks++;
         if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_leak[%0d] got32=%b got64=%b exp=0", s, bus32.out_valid, bus64.out_valid);
         end
      end
      flush = 1'b1; inValid = 1'b1; instr = 32'h00D00293; pc = 64'h30C;
      tick();
      flush = 1'b0; inValid = 1'b0;
      checks++;
      if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_drops_push got32=%b got64=%b exp=0", bus32.out_valid, bus64.out_valid);
      end
      d = '{instr: 32'h00E00313, pc: 64'h310};
      inValid = 1'b1; instr = d.instr; pc = d.pc;
      tick();
      inValid = 1'b0;
      checks++;
      if (got32() !== exp32(d) || got64() !== exp64(d) || bus64.out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_recover got=%h exp=%h", got64(), exp64(d));
      end
      tick();
   endtask

   task automatic test_reset_midstream();
      entry_t d;
      outReady = 1'b0;
      inValid  = 1'b1;
      instr = 32'h00100093; pc = 64'h400; tick();
      instr = 32'h00200113; pc = 64'h404; tick();
      inValid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus32.out_valid, bus32.in_ready, bus64.out_valid, bus64.in_ready} !== 4'b0101) begin
         errors++;
         $display("[TB] FAIL midreset_hs got=%b exp=0101", {bus32.out_valid, bus32.in_ready, bus64.out_valid, bus64.in_ready});
      end
      checks++;
      if (bus32.imm !== 32'd0 || bus64.imm !== 64'd0) begin
         errors++;
         $display("[TB] FAIL midreset_imm got32=%h got64=%h exp=0", bus32.imm, bus64.imm);
      end
      #1 rst_n = 1'b1;
      modelQ.delete();
      d = '{instr: 32'hFE512E23, pc: 64'h408};
      inValid = 1'b1; instr = d.instr; pc = d.pc;
      tick();
      inValid = 1'b0;
      checks++;
      if (got32() !== exp32(d) || got64() !== exp64(d) || bus32.out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_first got=%h exp=%h", got32(), exp32(d));
      end
      outReady = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic [31:0] r;
      for (int cyc = 0; cyc < 600; cyc++) begin
         inValid  = ($urandom_range(0, 9) < 7);
         outReady = ($urandom_range(0, 9) < 6);
         flush    = ($urandom_range(0, 39) == 0);
         r        = $urandom;
         if ($urandom_range(0, 4) == 0) instr = r;
         else                           instr = {r[31:7], opList[$urandom_range(0, 12)]};
         pc = {$urandom, $urandom};
         tick();
         checks++;
         if (bus32.out_valid !== (modelQ.size() > 0) || bus64.out_valid !== (modelQ.size() > 0)) begin
            errors++;
            $display("[TB] FAIL rand_valid[%0d] got32=%b got64=%b exp=%0d", cyc, bus32.out_valid, bus64.out_valid, modelQ.size() > 0);
         end
         checks++;
         if (bus32.in_ready !== (modelQ.size() < 2) || bus64.in_ready !== (modelQ.size() < 2)) begin
            errors++;
            $display("[TB] FAIL rand_ready[%0d] got32=%b got64=%b exp=%0d", cyc, bus32.in_ready, bus64.in_ready, modelQ.size() < 2);
         end
         if (modelQ.size() > 0) begin
            checks++;
            if (got32() !== exp32(modelQ[0])) begin
               errors++;
               $display("[TB] FAIL rand_bundle32[%0d] got=%h exp=%h", cyc, got32(), exp32(modelQ[0]));
            end
            checks++;
            if (got64() !== exp64(modelQ[0])) begin
               errors++;
               $display("[TB] FAIL rand_bundle64[%0d] got=%h exp=%h", cyc, got64(), exp64(modelQ[0]));
            end
         end
      end
      flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      opList = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h1B, 7'h3B};
      $display("[TB] decode_stage bench start");
      test_reset();
      test_decode();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
